// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between two pipeline stages.
// The master modport is the upstream/downstream environment; slave is the stage itself.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with optional skid entry,
// synchronous flush to a NOP bubble and a saturating backpressure counter.
module pipe_stage_reg #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk_PipeReg,
  input  logic             rstn_PipeReg,
  pipe_stage_reg_if.slave  bus,
  input  logic             flush,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              m_v;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic              s_v;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic              accept;
  logic              issue;

  // With SKID the constant select folds away the out_ready term, leaving in_ready registered.
  assign bus.in_ready  = (SKID != 0) ? !s_v : (bus.out_ready || !m_v);
  assign accept        = bus.in_valid && bus.in_ready;
  assign issue         = m_v && bus.out_ready;
  assign bus.out_valid = m_v;
  assign bus.out_data  = m_data;
  assign bus.out_ctrl  = m_ctrl;

  always_ff @(posedge clk_PipeReg or negedge rstn_PipeReg) begin
    if (!rstn_PipeReg) begin
      m_v    <= 1'b0;
      m_data <= '0;
      m_ctrl <= '0;
    end else if (flush) begin
      m_v    <= 1'b0;
      m_ctrl <= '0;
    end else if (s_v && issue) begin
      m_v    <= 1'b1;
      m_data <= s_data;
      m_ctrl <= s_ctrl;
    end else if (accept && (!m_v || issue)) begin
      m_v    <= 1'b1;
      m_data <= bus.in_data;
      m_ctrl <= bus.in_ctrl;
    end else if (issue) begin
      m_v    <= 1'b0;
      m_ctrl <= '0;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // S only fills when M is busy and stalled, so it is always the younger entry.
      always_ff @(posedge clk_PipeReg or negedge rstn_PipeReg) begin
        if (!rstn_PipeReg) begin
          s_v    <= 1'b0;
          s_data <= '0;
          s_ctrl <= '0;
        end else if (flush) begin
          s_v    <= 1'b0;
          s_ctrl <= '0;
        end else if (s_v && issue) begin
          s_v    <= 1'b0;
          s_ctrl <= '0;
        end else if (!s_v && accept && m_v && !issue) begin
          s_v    <= 1'b1;
          s_data <= bus.in_data;
          s_ctrl <= bus.in_ctrl;
        end
      end
    end else begin : g_no_skid
      assign s_v    = 1'b0;
      assign s_data = '0;
      assign s_ctrl = '0;
    end
  endgenerate

  always_ff @(posedge clk_PipeReg or negedge rstn_PipeReg) begin
    if (!rstn_PipeReg) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (m_v && !bus.out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a SKID=1/CNT_W=4 instance and a SKID=0 instance
// share stimulus; mode selects which one the reference model tracks.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [100:0] data;
    logic [7:0]   ctrl;
  } entry_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [100:0] in_data;
  logic [7:0]   in_ctrl;
  logic         out_ready;
  logic         flush;
  logic         clr_cnt;
  logic [3:0]   cnt_k;
  logic [15:0]  cnt_s;
  logic         mode;

  logic         obs_valid;
  logic         obs_ready;
  logic [100:0] obs_data;
  logic [7:0]   obs_ctrl;
  logic [15:0]  obs_cnt;

  entry_t       q[$];
  logic [15:0]  cnt_m;
  int           vectors;
  int           miscompares;
  int           issued;

  pipe_stage_reg_if #(.DATA_W(101), .CTRL_W(8)) bus_k ();
  pipe_stage_reg_if #(.DATA_W(101), .CTRL_W(8)) bus_s ();

  pipe_stage_reg #(.DATA_W(101), .CTRL_W(8), .SKID(1), .CNT_W(4)) dut_skid (
    .clk_PipeReg (clk),
    .rstn_PipeReg(rst_n),
    .bus         (bus_k),
    .flush       (flush),
    .clr_cnt     (clr_cnt),
    .stall_cnt   (cnt_k)
  );

  pipe_stage_reg #(.DATA_W(101), .CTRL_W(8), .SKID(0), .CNT_W(16)) dut_single (
    .clk_PipeReg (clk),
    .rstn_PipeReg(rst_n),
    .bus         (bus_s),
    .flush       (flush),
    .clr_cnt     (clr_cnt),
    .stall_cnt   (cnt_s)
  );

  assign bus_k.in_valid  = in_valid;
  assign bus_k.in_data   = in_data;
  assign bus_k.in_ctrl   = in_ctrl;
  assign bus_k.out_ready = out_ready;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.in_data   = in_data;
  assign bus_s.in_ctrl   = in_ctrl;
  assign bus_s.out_ready = out_ready;

  always_comb begin
    obs_valid = bus_k.out_valid;
    obs_ready = bus_k.in_ready;
    obs_data  = bus_k.out_data;
    obs_ctrl  = bus_k.out_ctrl;
    obs_cnt   = {12'd0, cnt_k};
    if (mode) begin
      obs_valid = bus_s.out_valid;
      obs_ready = bus_s.in_ready;
      obs_data  = bus_s.out_data;
      obs_ctrl  = bus_s.out_ctrl;
      obs_cnt   = cnt_s;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [100:0] d, input logic [7:0] c,
                               input logic ordy, input logic fl, input logic clr);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    clr_cnt   = clr;
  endtask

  // Compare mid-cycle against the model, then advance the model across the next edge.
  task automatic cycle();
    logic   ready_m;
    logic   issue_m;
    logic   accept_m;
    logic   stall_m;
    logic   has_m;
    entry_t e;
    @(negedge clk);
    if (!rst_n) begin
      checkOutput("rst_out_valid", obs_valid, 0);
      checkOutput("rst_out_ctrl", obs_ctrl, 0);
      checkOutput("rst_out_data", obs_data, 0);
      checkOutput("rst_stall_cnt", obs_cnt, 0);
      checkOutput("rst_in_ready", obs_ready, 1);
    end else begin
      has_m    = (q.size() != 0);
      ready_m  = mode ? (out_ready || !has_m) : (q.size() < 2);
      issue_m  = has_m && out_ready;
      accept_m = in_valid && ready_m;
      stall_m  = has_m && !out_ready;
      checkOutput("out_valid", obs_valid, has_m);
      checkOutput("in_ready", obs_ready, ready_m);
      checkOutput("stall_cnt", obs_cnt, cnt_m);
      if (!has_m) checkOutput("bubble_ctrl", obs_ctrl, 0);
      if (issue_m) begin
        e = q.pop_front();
        checkOutput("out_data", obs_data, e.data);
        checkOutput("out_ctrl", obs_ctrl, e.ctrl);
        issued++;
      end
      if (flush) q.delete();
      else if (accept_m) q.push_back('{data: in_data, ctrl: in_ctrl});
      if (clr_cnt) cnt_m = 16'd0;
      else if (stall_m && cnt_m != (mode ? 16'hFFFF : 16'h000F)) cnt_m = cnt_m + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b1, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle();
    rst_n = 1'b1;
    q.delete();
    cnt_m = 16'd0;
  endtask

  initial begin
    int issued_before;
    vectors     = 0;
    miscompares = 0;
    issued      = 0;
    mode        = 1'b0;
    cnt_m       = 16'd0;
    rst_n       = 1'b0;
    applyStimulus(1'b1, '0, 8'hFF, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    $display("[TB] reset and first-entry latency (SKID=1)");
    doReset();
    applyStimulus(1'b1, 101'h1_2345, 8'h5A, 1'b1, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("latency_valid", obs_valid, 1);
    checkOutput("latency_data", obs_data, 101'h1_2345);
    cycle();

    $display("[TB] streaming 10 entries");
    issued_before = issued;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 101'(i), 8'(i + 1), 1'b1, 1'b0, 1'b0);
      cycle();
    end
    applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle();
    checkOutput("stream_issues", issued - issued_before, 10);

    $display("[TB] backpressure A,B,C");
    applyStimulus(1'b1, 101'hA, 8'h0A, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 101'hB, 8'h0B, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 101'hC, 8'h0C, 1'b0, 1'b0, 1'b0);
    checkOutput("full_in_ready", obs_ready, 0);
    repeat (3) cycle();
    applyStimulus(1'b1, 101'hC, 8'h0C, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle();
    applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle();

    $display("[TB] flush with stage full");
    applyStimulus(1'b1, 101'hA, 8'h1A, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 101'hB, 8'h1B, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 101'hC, 8'h1C, 1'b0, 1'b1, 1'b0);
    cycle();
    checkOutput("flush_valid", obs_valid, 0);
    checkOutput("flush_ctrl", obs_ctrl, 0);
    checkOutput("flush_in_ready", obs_ready, 1);
    applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle();

    $display("[TB] counter saturation (CNT_W=4)");
    doReset();
    applyStimulus(1'b1, 101'h77, 8'h77, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (20) cycle();
    checkOutput("cnt_saturated", obs_cnt, 15);
    applyStimulus(1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle();
    checkOutput("cnt_cleared", obs_cnt, 0);
    applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle();

    $display("[TB] reset mid-transfer");
    applyStimulus(1'b1, 101'h55, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle();
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", obs_valid, 0);
    checkOutput("async_rst_ctrl", obs_ctrl, 0);
    @(posedge clk);
    #1;
    doReset();
    applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle();

    $display("[TB] single-entry mode (SKID=0)");
    mode = 1'b1;
    doReset();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, 101'(32'h100 + i), 8'(8'h40 + i), 1'((i % 2) == 0), 1'b0, 1'b0);
      cycle();
    end
    applyStimulus(1'b1, 101'h3FF, 8'h3F, 1'b0, 1'b1, 1'b0);
    cycle();
    checkOutput("single_flush_valid", obs_valid, 0);
    applyStimulus(1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
